prio_interrupt_controller: RTL and testbench

Parametrised, nesting interrupt controller sitting between external device interrupt lines and the core's trap/redirect logic. It supersedes the fixed-16-line, single-level `interrupt_controller`, adding:
- per-line programmable priority
- per-line edge/level trigger mode
- strict-priority preemption with a bounded nesting stack

It offers a vector PC to the core through a signal/ack handshake and unwinds on `interrupt_serviced`.

---
 rtl/prio_interrupt_controller_if.sv | 36 +++
 rtl/prio_interrupt_controller.sv | 209 ++++++++++++++++++++
 tb/tb_prio_interrupt_controller.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prio_interrupt_controller_if.sv
// Config bus plus core-side vector handshake of the priority interrupt controller.
// master = core/config agent side, slave = controller side.
interface prio_interrupt_controller_if #(
  parameter int unsigned INTERRUPT_LINES = 16,
  parameter int unsigned INTERRUPT_BITS  = $clog2(INTERRUPT_LINES),
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned NEST_DEPTH      = 4
);
  localparam int unsigned LEVEL_BITS = $clog2(NEST_DEPTH + 1);

  logic                      cfg_we;
  logic [1:0]                cfg_sel;
  logic [INTERRUPT_BITS-1:0] cfg_entry_id;
  logic [PC_WIDTH-1:0]       cfg_wdata;
  logic [PC_WIDTH-1:0]       cfg_rdata;
  logic                      signal_interrupt;
  logic [PC_WIDTH-1:0]       interrupt_PC;
  logic [INTERRUPT_BITS-1:0] signal_int_id;
  logic                      interrupt_ack;
  logic                      interrupt_serviced;
  logic                      in_service;
  logic [INTERRUPT_BITS-1:0] active_id;
  logic [LEVEL_BITS-1:0]     nest_level;

  modport master (
    output cfg_we, cfg_sel, cfg_entry_id, cfg_wdata, interrupt_ack, interrupt_serviced,
    input  cfg_rdata, signal_interrupt, interrupt_PC, signal_int_id, in_service, active_id,
           nest_level
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_entry_id, cfg_wdata, interrupt_ack, interrupt_serviced,
    output cfg_rdata, signal_interrupt, interrupt_PC, signal_int_id, in_service, active_id,
           nest_level
  );
endinterface

// File: rtl/prio_interrupt_controller.sv
// Nesting, priority-preemptive interrupt controller: per-line config, edge/level pending,
// registered vector offer with ack handshake, and a bounded stack of active handlers.
module prio_interrupt_controller #(
  parameter int unsigned INTERRUPT_LINES = 16,
  parameter int unsigned INTERRUPT_BITS  = $clog2(INTERRUPT_LINES),
  parameter int unsigned PRIO_BITS       = 3,
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned NEST_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INTERRUPT_LINES-1:0] interrupt_id,
  prio_interrupt_controller_if.slave bus
);
  localparam int unsigned LEVEL_BITS = $clog2(NEST_DEPTH + 1);

  typedef logic [INTERRUPT_BITS-1:0] line_t;
  typedef logic [PRIO_BITS-1:0]      prio_t;
  typedef logic [LEVEL_BITS-1:0]     level_t;
  typedef logic [PC_WIDTH-1:0]       pc_t;

  localparam level_t DEPTH_MAX = LEVEL_BITS'(NEST_DEPTH);

  // Per-line configuration
  logic [INTERRUPT_LINES-1:0] mask_q;
  logic [INTERRUPT_LINES-1:0] mode_q;
  pc_t                        vector_q [INTERRUPT_LINES];
  prio_t                      prio_q   [INTERRUPT_LINES];

  // Pending / edge detection
  logic [INTERRUPT_LINES-1:0] prev_q;
  logic [INTERRUPT_LINES-1:0] edge_pend_q, edge_pend_d;
  logic [INTERRUPT_LINES-1:0] ack_clr;
  logic [INTERRUPT_LINES-1:0] pending;

  // Handler stack
  line_t  stk_id_q   [NEST_DEPTH];
  line_t  stk_id_d   [NEST_DEPTH];
  prio_t  stk_prio_q [NEST_DEPTH];
  prio_t  stk_prio_d [NEST_DEPTH];
  level_t level_q, level_d;
  level_t base;
  logic   pop, push;
  line_t  top_id;
  prio_t  top_prio;

  // Registered offer
  logic  offer_q, offer_d;
  line_t offer_id_q, offer_id_d;
  prio_t offer_prio_q, offer_prio_d;
  pc_t   offer_pc_q, offer_pc_d;
  logic  ack_ok;

  // Arbitration result
  logic  room;
  logic  win_valid;
  line_t win_id;
  prio_t win_prio;
  pc_t   win_pc;

  assign ack_ok = bus.interrupt_ack & offer_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      mode_q <= '0;
      for (int i = 0; i < INTERRUPT_LINES; i++) begin
        vector_q[i] <= '0;
        prio_q[i]   <= '0;
      end
    end else if (bus.cfg_we) begin
      for (int i = 0; i < INTERRUPT_LINES; i++) begin
        if (line_t'(i) == bus.cfg_entry_id) begin
          unique case (bus.cfg_sel)
            2'd0: mask_q[i]   <= bus.cfg_wdata[0];
            2'd1: vector_q[i] <= bus.cfg_wdata;
            2'd2: prio_q[i]   <= bus.cfg_wdata[PRIO_BITS-1:0];
            2'd3: mode_q[i]   <= bus.cfg_wdata[0];
          endcase
        end
      end
    end
  end

  always_comb begin
    bus.cfg_rdata = '0;
    for (int i = 0; i < INTERRUPT_LINES; i++) begin
      if (line_t'(i) == bus.cfg_entry_id) begin
        unique case (bus.cfg_sel)
          2'd0: bus.cfg_rdata[0]             = mask_q[i];
          2'd1: bus.cfg_rdata                = vector_q[i];
          2'd2: bus.cfg_rdata[PRIO_BITS-1:0] = prio_q[i];
          2'd3: bus.cfg_rdata[0]             = mode_q[i];
        endcase
      end
    end
  end

  // Edge lines latch a rising sample until acked; level lines follow the input directly.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < INTERRUPT_LINES; i++) begin
      if (ack_ok && (line_t'(i) == offer_id_q)) ack_clr[i] = 1'b1;
    end
    edge_pend_d = (edge_pend_q & ~ack_clr) | (interrupt_id & ~prev_q & mode_q);
    pending     = (mode_q & edge_pend_q) | (~mode_q & interrupt_id);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= '0;
      edge_pend_q <= '0;
    end else begin
      prev_q      <= interrupt_id;
      edge_pend_q <= edge_pend_d;
    end
  end

  always_comb begin
    top_id   = '0;
    top_prio = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if ((level_q != '0) && (level_t'(i) == level_q - level_t'(1))) begin
        top_id   = stk_id_q[i];
        top_prio = stk_prio_q[i];
      end
    end
  end

  // Strict '>' on win_prio keeps the lowest index on ties.
  always_comb begin
    room      = level_q < DEPTH_MAX;
    win_valid = 1'b0;
    win_id    = '0;
    win_prio  = '0;
    win_pc    = '0;
    for (int i = 0; i < INTERRUPT_LINES; i++) begin
      if (pending[i] && mask_q[i] && room &&
          ((level_q == '0) || (prio_q[i] > top_prio)) &&
          (!win_valid || (prio_q[i] > win_prio))) begin
        win_valid = 1'b1;
        win_id    = line_t'(i);
        win_prio  = prio_q[i];
        win_pc    = vector_q[i];
      end
    end
  end

  always_comb begin
    offer_d      = win_valid & ~ack_ok;
    offer_id_d   = offer_d ? win_id : '0;
    offer_prio_d = offer_d ? win_prio : '0;
    offer_pc_d   = offer_d ? win_pc : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offer_q      <= 1'b0;
      offer_id_q   <= '0;
      offer_prio_q <= '0;
      offer_pc_q   <= '0;
    end else begin
      offer_q      <= offer_d;
      offer_id_q   <= offer_id_d;
      offer_prio_q <= offer_prio_d;
      offer_pc_q   <= offer_pc_d;
    end
  end

  // Pop first, then push at the resulting level: ack + serviced replaces the top.
  always_comb begin
    pop     = bus.interrupt_serviced && (level_q != '0);
    base    = pop ? level_q - level_t'(1) : level_q;
    push    = ack_ok && (base < DEPTH_MAX);
    level_d = push ? base + level_t'(1) : base;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      stk_id_d[i]   = stk_id_q[i];
      stk_prio_d[i] = stk_prio_q[i];
      if (push && (level_t'(i) == base)) begin
        stk_id_d[i]   = offer_id_q;
        stk_prio_d[i] = offer_prio_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        stk_id_q[i]   <= '0;
        stk_prio_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        stk_id_q[i]   <= stk_id_d[i];
        stk_prio_q[i] <= stk_prio_d[i];
      end
    end
  end

  assign bus.signal_interrupt = offer_q;
  assign bus.interrupt_PC     = offer_pc_q;
  assign bus.signal_int_id    = offer_id_q;
  assign bus.in_service       = (level_q != '0);
  assign bus.active_id        = top_id;
  assign bus.nest_level       = level_q;

endmodule

// File: tb/tb_prio_interrupt_controller.sv
// Directed bench for prio_interrupt_controller: config/arbitration tables plus
// hand-written nesting, preemption, stack-full, level/mask and reset sequences.
module tb_prio_interrupt_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq;
  int          checks = 0;
  int          errors = 0;

  prio_interrupt_controller_if bus ();

  prio_interrupt_controller dut (
    .clk         (clk),
    .rst         (rst),
    .interrupt_id(irq),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [3:0]  id;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } cfg_vec_t;

  typedef struct {
    logic [15:0] lines;
    logic        sig;
    logic [3:0]  id;
  } arb_vec_t;

  cfg_vec_t cfg_tab [7];
  arb_vec_t arb_tab [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [3:0] id, input logic [31:0] data);
    bus.cfg_we       = 1'b1;
    bus.cfg_sel      = sel;
    bus.cfg_entry_id = id;
    bus.cfg_wdata    = data;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic setup_line(input logic [3:0] id, input logic edge_mode, input logic [2:0] prio,
                            input logic [31:0] vec);
    cfg_write(2'd3, id, {31'd0, edge_mode});
    cfg_write(2'd2, id, {29'd0, prio});
    cfg_write(2'd1, id, vec);
    cfg_write(2'd0, id, 32'd1);
  endtask

  task automatic pulse(input logic [15:0] lines);
    irq = lines;
    tick();
    irq = '0;
  endtask

  task automatic ack();
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
  endtask

  task automatic serviced();
    bus.interrupt_serviced = 1'b1;
    tick();
    bus.interrupt_serviced = 1'b0;
  endtask

  task automatic do_reset();
    irq                    = '0;
    bus.interrupt_ack      = 1'b0;
    bus.interrupt_serviced = 1'b0;
    rst                    = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cfg_tab[0] = '{1'b1, 2'd0, 4'd5,  32'hFFFF_FFFF, 32'h1};
    cfg_tab[1] = '{1'b1, 2'd1, 4'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    cfg_tab[2] = '{1'b1, 2'd2, 4'd5,  32'h0000_000D, 32'h5};
    cfg_tab[3] = '{1'b1, 2'd3, 4'd5,  32'h0000_0002, 32'h0};
    cfg_tab[4] = '{1'b1, 2'd3, 4'd12, 32'h0000_0003, 32'h1};
    cfg_tab[5] = '{1'b0, 2'd1, 4'd4,  32'h0,         32'h0};
    cfg_tab[6] = '{1'b0, 2'd0, 4'd5,  32'h0,         32'h1};

    // Line i has priority (5*i)%8, vector 0x100+4*i; line 6 masked; all level mode.
    arb_tab[0]  = '{16'h0000, 1'b0, 4'd0};
    arb_tab[1]  = '{16'h0001, 1'b1, 4'd0};
    arb_tab[2]  = '{16'h0006, 1'b1, 4'd1};
    arb_tab[3]  = '{16'h0802, 1'b1, 4'd11};
    arb_tab[4]  = '{16'h0808, 1'b1, 4'd3};
    arb_tab[5]  = '{16'h0040, 1'b0, 4'd0};
    arb_tab[6]  = '{16'h0050, 1'b1, 4'd4};
    arb_tab[7]  = '{16'h8200, 1'b1, 4'd9};
    arb_tab[8]  = '{16'h2022, 1'b1, 4'd1};
    arb_tab[9]  = '{16'h1100, 1'b1, 4'd12};
    arb_tab[10] = '{16'hFFFF, 1'b1, 4'd3};

    irq                    = '0;
    bus.cfg_we             = 1'b0;
    bus.cfg_sel            = 2'd0;
    bus.cfg_entry_id       = 4'd0;
    bus.cfg_wdata          = '0;
    bus.interrupt_ack      = 1'b0;
    bus.interrupt_serviced = 1'b0;
    rst                    = 1'b1;
    #1;
    chk("reset_sig", 32'(bus.signal_interrupt), 32'd0);
    chk("reset_level", 32'(bus.nest_level), 32'd0);
    chk("reset_in_service", 32'(bus.in_service), 32'd0);
    chk("reset_cfg_rdata", bus.cfg_rdata, 32'd0);
    tick();
    rst = 1'b0;

    // Config read-back table
    for (int i = 0; i < 7; i++) begin
      if (cfg_tab[i].we) begin
        cfg_write(cfg_tab[i].sel, cfg_tab[i].id, cfg_tab[i].wdata);
      end
      bus.cfg_sel      = cfg_tab[i].sel;
      bus.cfg_entry_id = cfg_tab[i].id;
      #1;
      chk($sformatf("cfg_rdata[%0d]", i), bus.cfg_rdata, cfg_tab[i].rdata);
    end

    // Basic edge line, plus an ack with nothing offered
    do_reset();
    setup_line(4'd3, 1'b1, 3'd2, 32'h1000);
    ack();
    chk("stray_ack_level", 32'(bus.nest_level), 32'd0);
    pulse(16'h0008);
    chk("edge_not_yet", 32'(bus.signal_interrupt), 32'd0);
    tick();
    chk("edge_sig", 32'(bus.signal_interrupt), 32'd1);
    chk("edge_pc", bus.interrupt_PC, 32'h1000);
    chk("edge_id", 32'(bus.signal_int_id), 32'd3);
    ack();
    chk("edge_ack_sig", 32'(bus.signal_interrupt), 32'd0);
    chk("edge_ack_level", 32'(bus.nest_level), 32'd1);
    chk("edge_ack_active", 32'(bus.active_id), 32'd3);
    chk("edge_ack_in_service", 32'(bus.in_service), 32'd1);
    serviced();
    chk("edge_srv_level", 32'(bus.nest_level), 32'd0);
    chk("edge_srv_in_service", 32'(bus.in_service), 32'd0);

    // Arbitration table on level lines
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cfg_write(2'd2, 4'(i), 32'((i * 5) % 8));
      cfg_write(2'd1, 4'(i), 32'h100 + 32'(4 * i));
      cfg_write(2'd0, 4'(i), (i == 6) ? 32'd0 : 32'd1);
    end
    for (int i = 0; i < 11; i++) begin
      irq = arb_tab[i].lines;
      tick();
      chk($sformatf("arb_sig[%0d]", i), 32'(bus.signal_interrupt), 32'(arb_tab[i].sig));
      if (arb_tab[i].sig) begin
        chk($sformatf("arb_id[%0d]", i), 32'(bus.signal_int_id), 32'(arb_tab[i].id));
        chk($sformatf("arb_pc[%0d]", i), bus.interrupt_PC, 32'h100 + 32'(arb_tab[i].id) * 4);
      end
    end
    irq = '0;

    // Tie-break between lines 2 and 9
    do_reset();
    setup_line(4'd2, 1'b1, 3'd5, 32'h2000);
    setup_line(4'd9, 1'b1, 3'd5, 32'h9000);
    pulse(16'h0204);
    tick();
    chk("tie_first_id", 32'(bus.signal_int_id), 32'd2);
    ack();
    tick();
    chk("tie_no_equal_preempt", 32'(bus.signal_interrupt), 32'd0);
    serviced();
    tick();
    chk("tie_second_sig", 32'(bus.signal_interrupt), 32'd1);
    chk("tie_second_id", 32'(bus.signal_int_id), 32'd9);
    chk("tie_second_pc", bus.interrupt_PC, 32'h9000);

    // Preemption and priority gating
    do_reset();
    setup_line(4'd1, 1'b1, 3'd1, 32'h1100);
    setup_line(4'd7, 1'b1, 3'd4, 32'h7700);
    setup_line(4'd5, 1'b1, 3'd1, 32'h5500);
    pulse(16'h0002);
    tick();
    chk("pre_first_id", 32'(bus.signal_int_id), 32'd1);
    ack();
    pulse(16'h00A0);
    tick();
    chk("pre_offer_id", 32'(bus.signal_int_id), 32'd7);
    ack();
    chk("pre_level", 32'(bus.nest_level), 32'd2);
    chk("pre_active", 32'(bus.active_id), 32'd7);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("pre_gated[%0d]", k), 32'(bus.signal_interrupt), 32'd0);
    end
    serviced();
    chk("pre_pop_active", 32'(bus.active_id), 32'd1);
    tick();
    chk("pre_gated_l1", 32'(bus.signal_interrupt), 32'd0);
    serviced();
    chk("pre_pop_level", 32'(bus.nest_level), 32'd0);
    tick();
    chk("pre_late_sig", 32'(bus.signal_interrupt), 32'd1);
    chk("pre_late_id", 32'(bus.signal_int_id), 32'd5);

    // Stack full, then simultaneous ack + serviced
    do_reset();
    for (int l = 1; l <= 4; l++) setup_line(4'(l), 1'b1, 3'(l), 32'(l) << 12);
    setup_line(4'd8, 1'b1, 3'd7, 32'h8000);
    for (int l = 1; l <= 4; l++) begin
      pulse(16'd1 << l);
      tick();
      chk($sformatf("full_push_id[%0d]", l), 32'(bus.signal_int_id), 32'(l));
      ack();
    end
    chk("full_level", 32'(bus.nest_level), 32'd4);
    pulse(16'h0100);
    tick();
    tick();
    chk("full_no_offer", 32'(bus.signal_interrupt), 32'd0);
    serviced();
    chk("full_pop_level", 32'(bus.nest_level), 32'd3);
    tick();
    chk("full_late_sig", 32'(bus.signal_interrupt), 32'd1);
    chk("full_late_id", 32'(bus.signal_int_id), 32'd8);
    bus.interrupt_ack      = 1'b1;
    bus.interrupt_serviced = 1'b1;
    tick();
    bus.interrupt_ack      = 1'b0;
    bus.interrupt_serviced = 1'b0;
    chk("swap_level", 32'(bus.nest_level), 32'd3);
    chk("swap_active", 32'(bus.active_id), 32'd8);

    // Level line re-offer, then masked off
    do_reset();
    setup_line(4'd10, 1'b0, 3'd3, 32'hA000);
    irq = 16'h0400;
    tick();
    chk("lvl_sig", 32'(bus.signal_interrupt), 32'd1);
    chk("lvl_id", 32'(bus.signal_int_id), 32'd10);
    ack();
    chk("lvl_ack_level", 32'(bus.nest_level), 32'd1);
    tick();
    chk("lvl_held_no_offer", 32'(bus.signal_interrupt), 32'd0);
    serviced();
    chk("lvl_pop_sig", 32'(bus.signal_interrupt), 32'd0);
    tick();
    chk("lvl_reoffer", 32'(bus.signal_interrupt), 32'd1);
    cfg_write(2'd0, 4'd10, 32'd0);
    tick();
    chk("lvl_masked_drop", 32'(bus.signal_interrupt), 32'd0);
    irq = '0;

    // Reset mid-handler with an offer outstanding
    do_reset();
    setup_line(4'd1, 1'b1, 3'd1, 32'h1100);
    setup_line(4'd7, 1'b1, 3'd4, 32'h7700);
    setup_line(4'd12, 1'b1, 3'd6, 32'hC000);
    pulse(16'h0002);
    tick();
    ack();
    pulse(16'h0080);
    tick();
    ack();
    chk("rst_pre_level", 32'(bus.nest_level), 32'd2);
    pulse(16'h1000);
    tick();
    chk("rst_pre_sig", 32'(bus.signal_interrupt), 32'd1);
    #2;
    rst = 1'b1;
    bus.cfg_sel      = 2'd2;
    bus.cfg_entry_id = 4'd12;
    #1;
    chk("rst_level", 32'(bus.nest_level), 32'd0);
    chk("rst_in_service", 32'(bus.in_service), 32'd0);
    chk("rst_sig", 32'(bus.signal_interrupt), 32'd0);
    chk("rst_cfg_cleared", bus.cfg_rdata, 32'd0);
    tick();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
